// File: rtl/seg_scan_controller.sv
// Round-robin scan of the shared 4-digit seven-segment bus, with blanking gaps,
// leading-zero suppression and frame-synchronous double-buffered digit data.
module seg_scan_controller #(
    parameter int SCAN_DIV     = 4,
    parameter int BLANK_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] digits,
    input  logic        load,
    input  logic        lz_blank,
    output logic        load_ack,
    output logic        frame_start,
    output logic [3:0]  AN,
    output logic [6:0]  C
);
    localparam int            SW        = $clog2(SCAN_DIV);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] BLANK_END = SW'(BLANK_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_BLANK, S_DRIVE} state_t;

    state_t          r_state, w_state_nxt;
    logic [SW-1:0]   r_slot, w_slot_nxt;
    logic [1:0]      r_idx, w_idx_nxt;
    logic [3:0][3:0] r_disp, r_pend_buf, w_disp_nxt;
    logic            r_pend;
    logic            w_boundary, w_commit;
    logic            w_z3, w_z2, w_z1;
    logic [3:0]      w_lz, w_an, w_digit;
    logic [6:0]      w_c;

    function automatic logic [6:0] seg(input logic [3:0] v);
        case (v)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b0111111;
        endcase
    endfunction

    // State register: FSM state plus slot/digit position.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_slot  <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_slot  <= w_slot_nxt;
            r_idx   <= w_idx_nxt;
        end
    end

    // Next state: leaving IDLE lands on slot 0 of digit 0; the 2-bit index wraps 3->0.
    always_comb begin
        w_slot_nxt = '0;
        w_idx_nxt  = '0;
        if (enable && r_state != S_IDLE) begin
            if (r_slot == SLOT_LAST) begin
                w_idx_nxt = r_idx + 2'd1;
            end else begin
                w_slot_nxt = r_slot + 1'b1;
                w_idx_nxt  = r_idx;
            end
        end
        if (!enable)
            w_state_nxt = S_IDLE;
        else if (w_slot_nxt < BLANK_END)
            w_state_nxt = S_BLANK;
        else
            w_state_nxt = S_DRIVE;
    end

    assign w_boundary = enable && (w_slot_nxt == '0) && (w_idx_nxt == 2'd0);
    assign w_commit   = w_boundary && r_pend;
    assign w_disp_nxt = w_commit ? r_pend_buf : r_disp;

    // A load coinciding with a boundary stays pending; the boundary commits the older value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_disp     <= '0;
            r_pend_buf <= '0;
            r_pend     <= 1'b0;
        end else begin
            if (load)
                r_pend_buf <= digits;
            if (w_commit)
                r_disp <= r_pend_buf;
            if (load)
                r_pend <= 1'b1;
            else if (w_boundary)
                r_pend <= 1'b0;
        end
    end

    assign w_z3    = (w_disp_nxt[3] == 4'd0);
    assign w_z2    = (w_disp_nxt[2] == 4'd0);
    assign w_z1    = (w_disp_nxt[1] == 4'd0);
    assign w_lz    = {lz_blank && w_z3, lz_blank && w_z3 && w_z2,
                      lz_blank && w_z3 && w_z2 && w_z1, 1'b0};
    assign w_digit = w_disp_nxt[w_idx_nxt];

    // Output decode works on the post-edge position and buffer so the registers line up.
    always_comb begin
        w_an = 4'b1111;
        w_c  = 7'b1111111;
        if (w_state_nxt == S_DRIVE && !w_lz[w_idx_nxt]) begin
            w_an[w_idx_nxt] = 1'b0;
            w_c             = seg(w_digit);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            AN          <= 4'b1111;
            C           <= 7'b1111111;
            frame_start <= 1'b0;
            load_ack    <= 1'b0;
        end else begin
            AN          <= w_an;
            C           <= w_c;
            frame_start <= w_boundary;
            load_ack    <= w_commit;
        end
    end
endmodule
